fir_engine_ctrl: RTL and testbench

//  Sequencer for the FIR MAC datapath. Owns the ap_start/ap_done/ap_idle protocol and the data-RAM

---
 rtl/fir_engine_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fir_engine_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine_ctrl.sv
// Sequencer for the FIR MAC datapath: ap_start/ap_done/ap_idle protocol, data-RAM clear,
// per-tap BRAM addressing, MAC strobes and the ss/sm stream handshakes.
module fir_engine_ctrl #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned Tape_Num    = 11,
    parameter int unsigned LEN_WIDTH   = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic                   ctrl_rd,
    input  logic [LEN_WIDTH-1:0]   data_length,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   tap_lock,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   data_wsel,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   mac_en,
    output logic                   mac_first,
    output logic                   tlast_err
);

    localparam int unsigned   KW    = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam logic [KW-1:0] KLast = KW'(Tape_Num - 1);
    localparam logic [KW:0]   KNum  = (KW + 1)'(Tape_Num);

    typedef enum logic [2:0] {
        StIdle, StClear, StWaitX, StMac, StDrain, StOut, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [KW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 tlast_err_q, tlast_err_d;
    logic                 mac_en_q, mac_first_q;
    logic                 start_ok;
    logic                 last_sample;
    logic [KW:0]          rd_sum;
    logic [KW-1:0]        rd_idx;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [KW-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign start_ok    = ap_start && (state_q == StIdle || state_q == StDone);
    assign last_sample = (count_q == len_q - 1'b1);

    // Circular read index: newest sample at k=0, walking backwards through the data RAM.
    always_comb begin
        rd_sum = {1'b0, wr_ptr_q} - {1'b0, k_q};
        if (wr_ptr_q < k_q) begin
            rd_sum = rd_sum + KNum;
        end
        rd_idx = rd_sum[KW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        tlast_err_d = tlast_err_q;
        case (state_q)
            StIdle: state_d = StIdle;
            StClear: begin
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = (len_q == '0) ? StDone : StWaitX;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StWaitX: begin
                if (ss_tvalid) begin
                    state_d = StMac;
                    k_d     = '0;
                    if (ss_tlast != last_sample) begin
                        tlast_err_d = 1'b1;
                    end
                end
            end
            StMac: begin
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                wr_ptr_d = (wr_ptr_q == KLast) ? '0 : wr_ptr_q + 1'b1;
                state_d  = StOut;
            end
            StOut: begin
                if (sm_tready) begin
                    count_d = count_q + 1'b1;
                    state_d = (count_q + 1'b1 == len_q) ? StDone : StWaitX;
                end
            end
            StDone: begin
                if (ctrl_rd) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Start outranks a same-cycle status read.
        if (start_ok) begin
            state_d     = StClear;
            len_d       = data_length;
            count_d     = '0;
            wr_ptr_d    = '0;
            k_d         = '0;
            tlast_err_d = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            tlast_err_q <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            tlast_err_q <= tlast_err_d;
            // BRAM read latency is one cycle, so the MAC strobe trails the address issue.
            mac_en_q    <= (state_q == StMac);
            mac_first_q <= (state_q == StMac) && (k_q == '0);
        end
    end

    always_comb begin
        ap_done   = 1'b0;
        ap_idle   = 1'b0;
        tap_lock  = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_wsel = 1'b0;
        tap_A     = '0;
        case (state_q)
            StIdle: ap_idle = 1'b1;
            StClear: begin
                tap_lock = 1'b1;
                data_EN  = 1'b1;
                data_WE  = 4'hF;
                data_A   = word_addr(k_q);
            end
            StWaitX: begin
                tap_lock  = 1'b1;
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    data_wsel = 1'b1;
                    data_A    = word_addr(wr_ptr_q);
                end
            end
            StMac: begin
                tap_lock = 1'b1;
                data_EN  = 1'b1;
                data_A   = word_addr(rd_idx);
                tap_A    = word_addr(k_q);
            end
            StDrain: tap_lock = 1'b1;
            StOut: begin
                tap_lock  = 1'b1;
                sm_tvalid = 1'b1;
                sm_tlast  = last_sample;
            end
            StDone: begin
                ap_done = 1'b1;
                ap_idle = 1'b1;
            end
            default: ap_idle = 1'b0;
        endcase
    end

    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign tlast_err = tlast_err_q;

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Directed bench for fir_engine_ctrl: models the tap/data BRAMs and the accumulator around the
// sequencer and checks y values, handshakes, addressing and status against hand-computed values.
module tb_fir_engine_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned NT = 11;
    localparam int unsigned LW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ctrl_rd = 1'b0;
    logic [LW-1:0] data_length = '0;
    logic          ap_done, ap_idle, tap_lock;
    logic          ss_tvalid = 1'b0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          sm_tready = 1'b0;
    logic          sm_tvalid, sm_tlast;
    logic          data_EN;
    logic [3:0]    data_WE;
    logic [AW-1:0] data_A;
    logic          data_wsel;
    logic [AW-1:0] tap_A;
    logic          mac_en, mac_first, tlast_err;

    logic [31:0] ss_tdata = '0;
    logic [31:0] tap_mem [NT];
    logic [31:0] data_mem [NT];
    logic [31:0] tap_do, data_do, acc;

    int n_cmp = 0;
    int n_err = 0;

    fir_engine_ctrl #(
        .pADDR_WIDTH (AW),
        .Tape_Num    (NT),
        .LEN_WIDTH   (LW)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .ctrl_rd     (ctrl_rd),
        .data_length (data_length),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .tap_lock    (tap_lock),
        .ss_tvalid   (ss_tvalid),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tready   (sm_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tlast    (sm_tlast),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_wsel   (data_wsel),
        .tap_A       (tap_A),
        .mac_en      (mac_en),
        .mac_first   (mac_first),
        .tlast_err   (tlast_err)
    );

    always #5 axis_clk = ~axis_clk;

    // Datapath model: 1-cycle-latency BRAMs and the multiply/accumulate stage.
    always @(posedge axis_clk) begin
        int di, ti;
        di = int'(data_A >> 2);
        ti = int'(tap_A >> 2);
        tap_do <= (ti < NT) ? tap_mem[ti] : 32'hDEAD;
        if (data_EN && di < NT) begin
            if (data_WE == 4'hF) data_mem[di] <= data_wsel ? ss_tdata : 32'h0;
            data_do <= data_mem[di];
        end
        if (mac_en) acc <= mac_first ? tap_do * data_do : acc + tap_do * data_do;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, " ap_idle"}, 64'(ap_idle), 64'd1);
        check_val({tag, " outputs"}, 64'({ap_done, tap_lock, ss_tready, sm_tvalid, sm_tlast,
            data_EN, data_WE, data_A, data_wsel, tap_A, mac_en, mac_first, tlast_err}), 64'd0);
    endtask

    task automatic start_run(input logic [LW-1:0] len, input logic with_rd);
        @(negedge axis_clk);
        ap_start    = 1'b1;
        ctrl_rd     = with_rd;
        data_length = len;
        @(negedge axis_clk);
        ap_start = 1'b0;
        ctrl_rd  = 1'b0;
    endtask

    task automatic send_x(input logic [31:0] x, input logic last);
        int n = 0;
        while (!ss_tready && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        check_val("ss_tready before send", 64'(ss_tready), 64'd1);
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        ss_tlast  = last;
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic recv_y(input string tag, input logic [31:0] y, input logic last,
                          input int stall, output int waited);
        bit ok;
        waited = 0;
        while (!sm_tvalid && waited < 200) begin
            @(negedge axis_clk);
            waited++;
        end
        check_val({tag, " sm_tvalid"}, 64'(sm_tvalid), 64'd1);
        check_val({tag, " y"}, 64'(acc), 64'(y));
        check_val({tag, " sm_tlast"}, 64'(sm_tlast), 64'(last));
        if (stall > 0) begin
            ok = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge axis_clk);
                if (!sm_tvalid || acc !== y || ss_tready || sm_tlast !== last) ok = 1'b0;
            end
            check_val({tag, " stall hold"}, 64'(ok), 64'd1);
        end
        sm_tready = 1'b1;
        @(negedge axis_clk);
        sm_tready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit ok;
        int y14 [14] = '{1, 4, 10, 20, 35, 56, 84, 120, 165, 220, 286, 352, 418, 484};
        int y5 [5] = '{1, 3, 6, 10, 15};
        for (int i = 0; i < NT; i++) tap_mem[i] = 32'(i + 1);

        repeat (2) @(negedge axis_clk);
        check_reset_outs("reset");
        axis_rst_n = 1'b1;

        // Clear sweep after start, len=3.
        start_run(32'd3, 1'b0);
        check_val("ap_idle after start", 64'(ap_idle), 64'd0);
        check_val("tap_lock in clear", 64'(tap_lock), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < NT; i++) begin
            check_val($sformatf("clear addr %0d", i), 64'(data_A), 64'(i * 4));
            if (!data_EN || data_WE != 4'hF || data_wsel) ok = 1'b0;
            @(negedge axis_clk);
        end
        check_val("clear strobes", 64'(ok), 64'd1);
        check_val("ss_tready after clear", 64'(ss_tready), 64'd1);

        // x={1,2,3}: y={1,4,10}, with a 20-cycle output stall on the second y.
        send_x(32'd1, 1'b0);
        recv_y("run3 y0", 32'd1, 1'b0, 0, w);
        check_val("accept-to-valid latency", 64'(w), 64'(NT + 1));
        send_x(32'd2, 1'b0);
        recv_y("run3 y1", 32'd4, 1'b0, 20, w);
        send_x(32'd3, 1'b1);
        recv_y("run3 y2", 32'd10, 1'b1, 0, w);
        check_val("run3 ap_done", 64'(ap_done), 64'd1);
        check_val("run3 ap_idle", 64'(ap_idle), 64'd1);
        check_val("run3 tap_lock", 64'(tap_lock), 64'd0);
        check_val("run3 tlast_err", 64'(tlast_err), 64'd0);

        // Status read clears ap_done; ap_idle remains.
        @(negedge axis_clk);
        ctrl_rd = 1'b1;
        @(negedge axis_clk);
        ctrl_rd = 1'b0;
        check_val("ctrl_rd ap_done", 64'(ap_done), 64'd0);
        check_val("ctrl_rd ap_idle", 64'(ap_idle), 64'd1);

        // len=14 with x[n]=n+1: pointer wrap, read order, ignored mid-run start.
        start_run(32'd14, 1'b0);
        for (int n = 0; n < 14; n++) begin
            send_x(32'(n + 1), n == 13);
            if (n == 0) begin
                ap_start    = 1'b1;
                data_length = 32'd1;
                @(negedge axis_clk);
                ap_start = 1'b0;
                check_val("mid-run start ap_idle", 64'(ap_idle), 64'd0);
                check_val("mid-run start tap_lock", 64'(tap_lock), 64'd1);
            end
            if (n == 12) begin
                check_val("wrap data_A k0", 64'(data_A), 64'h04);
                check_val("wrap tap_A k0", 64'(tap_A), 64'h00);
                @(negedge axis_clk);
                check_val("wrap data_A k1", 64'(data_A), 64'h00);
                @(negedge axis_clk);
                check_val("wrap data_A k2", 64'(data_A), 64'h28);
                repeat (8) @(negedge axis_clk);
                check_val("wrap data_A k10", 64'(data_A), 64'h08);
                check_val("wrap tap_A k10", 64'(tap_A), 64'h28);
            end
            recv_y($sformatf("run14 y%0d", n), 32'(y14[n]), n == 13, 0, w);
        end
        check_val("run14 ap_done", 64'(ap_done), 64'd1);
        check_val("run14 tlast_err", 64'(tlast_err), 64'd0);

        // Start together with ctrl_rd in DONE; early tlast on sample 2 of len=5.
        start_run(32'd5, 1'b1);
        check_val("start+rd ap_idle", 64'(ap_idle), 64'd0);
        check_val("start+rd tap_lock", 64'(tap_lock), 64'd1);
        for (int n = 0; n < 5; n++) begin
            send_x(32'd1, n == 1);
            if (n == 1) check_val("early tlast err", 64'(tlast_err), 64'd1);
            recv_y($sformatf("run5 y%0d", n), 32'(y5[n]), n == 4, 0, w);
        end
        check_val("run5 ap_done", 64'(ap_done), 64'd1);
        check_val("run5 tlast_err sticky", 64'(tlast_err), 64'd1);

        // New start clears tlast_err; reset during MAC returns to reset state.
        start_run(32'd2, 1'b0);
        check_val("restart tlast_err", 64'(tlast_err), 64'd0);
        send_x(32'd7, 1'b0);
        repeat (2) @(negedge axis_clk);
        check_val("mac_en in MAC", 64'(mac_en), 64'd1);
        axis_rst_n = 1'b0;
        #1;
        check_reset_outs("mid-run reset");
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_reset_outs("after reset release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
